// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, packs it into
// 16-bit words written to instruction memory from address 0, and releases the MCU on success.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [7:0]  hi_byte;

    logic        accept_c;
    logic [15:0] n_len_c;
    logic [31:0] words_next_c;

    assign accept_c     = rx_valid & rx_ready;
    assign n_len_c      = {len[15:8], rx_data};
    // Count including the word being accepted now; the previous write's increment
    // has always landed by the earliest possible next DATA_LO byte.
    assign words_next_c = 32'(words_loaded) + 32'd1;

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= S_LEN_HI;
            rx_ready     <= 1'b1;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            core_run     <= 1'b0;
            busy         <= 1'b1;
            error        <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            csum         <= '0;
            hi_byte      <= '0;
        end else begin
            im_we <= 1'b0;

            // Post-write bookkeeping; im_addr wraps naturally after the last of 2**ADDR_W words.
            if (im_we) begin
                im_addr      <= im_addr + ADDR_W'(1);
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end

            if (accept_c) begin
                if (state != S_CHECK) begin
                    csum <= csum ^ rx_data;
                end

                case (state)
                    S_LEN_HI: begin
                        len[15:8] <= rx_data;
                        state     <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= rx_data;
                        if (32'(n_len_c) > DEPTH) begin
                            state    <= S_ERROR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else if (n_len_c == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        hi_byte <= rx_data;
                        state   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        im_we    <= 1'b1;
                        im_wdata <= {hi_byte, rx_data};
                        if (words_next_c < 32'(len)) begin
                            state <= S_DATA_HI;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == csum) begin
                            state    <= S_RUN;
                            core_run <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of load scenarios plus hand-written clear sequences,
// with a write scoreboard fed by the driver and drained by an im_we monitor.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              clear;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;
    logic              core_run;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .clear        (clear),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .core_run     (core_run),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        int unsigned n;
        bit          fixed_data;
        bit          bad_csum;
        int          stall_pct;
        bit          exp_run;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    vec_t        vecs[7];
    wr_t         sb[$];
    logic [15:0] mem_seen [0:255];
    int          total;
    int          bad;
    bit          chk_run_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every im_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (im_we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0h data=%0h", im_addr, im_wdata);
            end else begin
                e = sb.pop_front();
                if (e.addr !== im_addr || e.data !== im_wdata) begin
                    bad++;
                    $display("FAIL write got addr=%0h data=%0h exp addr=%0h data=%0h",
                             im_addr, im_wdata, e.addr, e.data);
                end
            end
            mem_seen[im_addr] = im_wdata;
        end
        if (chk_run_low) begin
            total++;
            if (core_run !== 1'b0) begin
                bad++;
                $display("FAIL core_run_during_reload got=%0b exp=0", core_run);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int stall_pct, output bit acc);
        int k;
        k = 0;
        while (stall_pct > 0 && k < 8 && $urandom_range(99, 0) < stall_pct) begin
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        acc      = rx_ready;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic run_stream(input int unsigned n, input bit fixed_data, input bit bad_csum,
                              input int stall_pct, input bit exp_run);
        logic [15:0] ln;
        logic [15:0] w;
        logic [7:0]  cs;
        bit          acc;
        ln = 16'(n);
        cs = 8'h00;
        send(ln[15:8], stall_pct, acc);
        cs ^= ln[15:8];
        send(ln[7:0], stall_pct, acc);
        cs ^= ln[7:0];
        if (n <= 256) begin
            for (int i = 0; i < int'(n); i++) begin
                if (fixed_data) w = (i == 0) ? 16'h1234 : 16'hABCD;
                else            w = 16'($urandom);
                send(w[15:8], stall_pct, acc);
                if (acc) sb.push_back('{ADDR_W'(i), w});
                send(w[7:0], stall_pct, acc);
                cs ^= w[15:8] ^ w[7:0];
            end
            chk_run_low = 1'b0;
            send(bad_csum ? (cs ^ 8'h03) : cs, stall_pct, acc);
            chk("core_run_after_csum", 32'(core_run), 32'(exp_run));
        end else begin
            send(cs, 0, acc);
            chk("byte_refused_in_error", 32'(acc), 32'd0);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        chk_run_low = 1'b0;
        clear       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_addr", 32'(im_addr), 32'd0);
        chk("rst_im_wdata", 32'(im_wdata), 32'd0);
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        clear = 1'b0;

        vecs[0] = '{2,     1'b1, 1'b0, 0,  1'b1, 1'b0};
        vecs[1] = '{2,     1'b1, 1'b1, 0,  1'b0, 1'b1};
        vecs[2] = '{0,     1'b0, 1'b0, 0,  1'b1, 1'b0};
        vecs[3] = '{257,   1'b0, 1'b0, 0,  1'b0, 1'b1};
        vecs[4] = '{256,   1'b0, 1'b0, 0,  1'b1, 1'b0};
        vecs[5] = '{2,     1'b1, 1'b0, 50, 1'b1, 1'b0};
        vecs[6] = '{5,     1'b0, 1'b0, 30, 1'b1, 1'b0};

        for (int v = 0; v < 7; v++) begin
            int unsigned ew;
            do_clear();
            run_stream(vecs[v].n, vecs[v].fixed_data, vecs[v].bad_csum,
                       vecs[v].stall_pct, vecs[v].exp_run);
            repeat (3) @(posedge clk);
            #1;
            ew = (vecs[v].n <= 256) ? vecs[v].n : 0;
            chk($sformatf("v%0d_core_run", v), 32'(core_run), 32'(vecs[v].exp_run));
            chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_rx_ready", v), 32'(rx_ready), 32'd0);
            chk($sformatf("v%0d_words", v), 32'(words_loaded), ew);
            chk($sformatf("v%0d_im_addr", v), 32'(im_addr), ew % 256);
            chk($sformatf("v%0d_sb_empty", v), 32'(sb.size()), 32'd0);
            sb.delete();
        end

        // Clear after the third payload byte, with a byte offered in the clear cycle.
        begin
            bit acc;
            do_clear();
            send(8'h00, 0, acc);
            send(8'h02, 0, acc);
            send(8'h12, 0, acc);
            sb.push_back('{ADDR_W'(0), 16'h1234});
            send(8'h34, 0, acc);
            send(8'hAB, 0, acc);
            rx_data  = 8'hFF;
            rx_valid = 1'b1;
            clear    = 1'b1;
            @(posedge clk);
            #1;
            clear    = 1'b0;
            rx_valid = 1'b0;
            chk("mid_clear_words", 32'(words_loaded), 32'd0);
            chk("mid_clear_addr", 32'(im_addr), 32'd0);
            chk("mid_clear_busy", 32'(busy), 32'd1);
            chk("mid_clear_sb_empty", 32'(sb.size()), 32'd0);
            mem_seen[0] = 16'h0000;
            mem_seen[1] = 16'h0000;
            chk_run_low = 1'b1;
            run_stream(2, 1'b1, 1'b0, 0, 1'b1);
            repeat (2) @(posedge clk);
            #1;
            chk("reload_mem0", 32'(mem_seen[0]), 32'h1234);
            chk("reload_mem1", 32'(mem_seen[1]), 32'hABCD);
            chk("reload_words", 32'(words_loaded), 32'd2);
            chk("reload_error", 32'(error), 32'd0);
            // Clear while running drops core_run on the next cycle.
            clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            chk("run_clear_core_run", 32'(core_run), 32'd0);
            chk("run_clear_rx_ready", 32'(rx_ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
